// File: rtl/weight_stream_mem.sv
// Weight memory that streams a window of words, with a ready/valid output and optional looping.
// The read pipeline has a registered BRAM output stage feeding a registered output stage.
module weight_stream_mem #(
    parameter int unsigned DATA_BITWIDTH = 8,
    parameter int unsigned ADDR_BITWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     wr_en,
    input  logic [ADDR_BITWIDTH-1:0] wr_addr,
    input  logic [DATA_BITWIDTH-1:0] wr_data,
    output logic                     wr_err,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    input  logic [ADDR_BITWIDTH:0]   len,
    input  logic                     loop_en,
    input  logic                     abort,
    output logic [DATA_BITWIDTH-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned DEPTH = 1 << ADDR_BITWIDTH;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_BITWIDTH-1:0] r_mem [DEPTH];
    logic [DATA_BITWIDTH-1:0] r_mem_q;
    logic                     r_s1_valid;
    logic                     r_s1_last;

    logic [ADDR_BITWIDTH-1:0] r_base;
    logic [ADDR_BITWIDTH-1:0] r_rd_addr;
    logic [ADDR_BITWIDTH:0]   r_rd_cnt;
    logic [ADDR_BITWIDTH:0]   r_last_idx;
    logic                     r_loop;
    logic                     r_issuing;

    logic [DATA_BITWIDTH-1:0] r_dout;
    logic                     r_dout_valid;
    logic                     r_dout_last;
    logic                     r_done;
    logic                     r_wr_err;

    logic w_streaming;
    logic w_start_ok;
    logic w_out_adv;
    logic w_s1_adv;
    logic w_issue;
    logic w_pass_end;
    logic w_final_xfer;

    assign w_streaming  = (r_state == S_STREAM);
    assign w_start_ok   = start && (len != '0);
    // A stage may accept new data when it is empty or its content moves on this edge.
    assign w_out_adv    = !r_dout_valid || dout_ready;
    assign w_s1_adv     = !r_s1_valid || w_out_adv;
    assign w_issue      = w_streaming && !abort && r_issuing && w_s1_adv;
    assign w_pass_end   = (r_rd_cnt == r_last_idx);
    assign w_final_xfer = w_streaming && !abort && !r_loop && r_dout_valid && dout_ready && r_dout_last;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_state_next = S_STREAM;
            S_STREAM: if (abort || w_final_xfer) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Storage and read register carry no reset so they map onto block RAM and keep contents.
    always_ff @(posedge clk) begin
        if (rstN && wr_en && !w_streaming) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_issue) begin
            r_mem_q <= r_mem[r_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_issuing    <= 1'b0;
            r_base       <= '0;
            r_rd_addr    <= '0;
            r_rd_cnt     <= '0;
            r_last_idx   <= '0;
            r_loop       <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_done       <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_wr_err <= wr_en && w_streaming;
            r_done   <= w_final_xfer;
            if (!w_streaming) begin
                r_s1_valid   <= 1'b0;
                r_dout_valid <= 1'b0;
                r_issuing    <= 1'b0;
                if (w_start_ok) begin
                    r_base     <= base_addr;
                    r_rd_addr  <= base_addr;
                    r_rd_cnt   <= '0;
                    r_last_idx <= len - (ADDR_BITWIDTH+1)'(1);
                    r_loop     <= loop_en;
                    r_issuing  <= 1'b1;
                end
            end else if (abort) begin
                r_s1_valid   <= 1'b0;
                r_dout_valid <= 1'b0;
                r_issuing    <= 1'b0;
            end else begin
                if (w_out_adv) begin
                    r_dout_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_dout      <= r_mem_q;
                        r_dout_last <= r_s1_last;
                    end
                end
                if (w_issue) begin
                    r_s1_valid <= 1'b1;
                    r_s1_last  <= w_pass_end;
                    if (w_pass_end) begin
                        r_rd_cnt  <= '0;
                        r_rd_addr <= r_base;
                        r_issuing <= r_loop;
                    end else begin
                        r_rd_cnt  <= r_rd_cnt + (ADDR_BITWIDTH+1)'(1);
                        r_rd_addr <= r_rd_addr + ADDR_BITWIDTH'(1);
                    end
                end else if (w_out_adv) begin
                    r_s1_valid <= 1'b0;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign busy       = w_streaming;
    assign done       = r_done;
    assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed bench for weight_stream_mem: memory holds addr+1, streams are compared word by word.
module tb_weight_stream_mem;
    logic       clk = 1'b0;
    logic       rstN;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] len;
    logic       loop_en;
    logic       abort;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent collect() call.
    logic [7:0] c_wd [20];
    logic       c_wl [20];
    int         c_wc [20];
    int         c_got;
    int         c_dones;
    int         c_first;
    bit         c_held_ok;
    bit         c_post_valid;
    bit         c_post_busy;
    bit         c_timeout;

    weight_stream_mem #(
        .DATA_BITWIDTH(8),
        .ADDR_BITWIDTH(4)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .loop_en   (loop_en),
        .abort     (abort),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Drives one stream request and records what the consumer sees. rmode 0: ready held high,
    // rmode 1: ready high one cycle in three. abort_after > 0 aborts once that many words arrived.
    task automatic collect(input logic [3:0] b, input logic [4:0] ln, input logic lp,
                           input int rmode, input int abort_after, input int n_expect);
        logic       v, l, pd_l, r, prev_stall, aborted, finished;
        logic [7:0] d, pd;
        int         last_i, abort_i;
        c_got = 0; c_dones = 0; c_first = -1; c_held_ok = 1'b1;
        c_post_valid = 1'b1; c_post_busy = 1'b1; c_timeout = 1'b0;
        prev_stall = 1'b0; aborted = 1'b0; finished = 1'b0;
        last_i = 0; abort_i = 0; pd = '0; pd_l = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = b; len = ln; loop_en = lp; dout_ready = (rmode == 0);
        for (int i = 1; i <= 100 && !finished; i++) begin
            @(negedge clk);
            start = 1'b0;
            v = dout_valid; d = dout; l = dout_last;
            if (done) c_dones++;
            if (prev_stall && (!v || d !== pd || l !== pd_l)) c_held_ok = 1'b0;
            if (v && c_first < 0) c_first = i;
            if (aborted) begin
                if (i == abort_i + 1) begin
                    c_post_valid = dout_valid;
                    c_post_busy  = busy;
                    abort = 1'b0;
                end
                if (i >= abort_i + 4) finished = 1'b1;
                prev_stall = 1'b0;
            end else if (abort_after > 0 && c_got >= abort_after) begin
                abort = 1'b1; dout_ready = 1'b1; aborted = 1'b1; abort_i = i;
                prev_stall = 1'b0;
            end else if (abort_after == 0 && c_got >= n_expect && i >= last_i + 3) begin
                finished = 1'b1;
            end else begin
                r = (rmode == 0) ? 1'b1 : ((i % 3) == 0);
                dout_ready = r;
                if (v && r) begin
                    if (c_got < 20) begin
                        c_wd[c_got] = d; c_wl[c_got] = l; c_wc[c_got] = i;
                    end
                    c_got++;
                    last_i = i;
                end
                prev_stall = v && !r;
                pd = d; pd_l = l;
            end
        end
        if (!finished) c_timeout = 1'b1;
        abort = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        base_addr = '0; len = '0; loop_en = 1'b0; abort = 1'b0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (dout !== 8'd0)     begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        n_checks++; if (dout_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b expected 0", dout_last); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (wr_err !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        bit err_seen;
        err_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i + 1);
            @(negedge clk);
            if (wr_err !== 1'b0) err_seen = 1'b1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL load_wr_err: got %b expected 0", err_seen); end
    endtask

    task automatic test_oneshot();
        collect(4'd0, 5'd4, 1'b0, 0, 0, 4);
        n_checks++; if (c_timeout !== 1'b0) begin n_fail++; $display("FAIL oneshot_timeout: got %b expected 0", c_timeout); end
        n_checks++; if (c_got !== 4) begin n_fail++; $display("FAIL oneshot_count: got %0d expected 4", c_got); end
        n_checks++; if (c_first !== 3) begin n_fail++; $display("FAIL oneshot_latency: got %0d expected 3", c_first); end
        for (int k = 0; k < 4 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL oneshot_word%0d: got %0d expected %0d", k, c_wd[k], k + 1); end
            n_checks++; if (c_wl[k] !== (k == 3)) begin n_fail++; $display("FAIL oneshot_last%0d: got %b expected %b", k, c_wl[k], k == 3); end
            n_checks++; if (c_wc[k] !== c_wc[0] + k) begin n_fail++; $display("FAIL oneshot_gap%0d: got cycle %0d expected %0d", k, c_wc[k], c_wc[0] + k); end
        end
        n_checks++; if (c_dones !== 1) begin n_fail++; $display("FAIL oneshot_done: got %0d pulses expected 1", c_dones); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w [4];
        exp_w[0] = 8'd15; exp_w[1] = 8'd16; exp_w[2] = 8'd1; exp_w[3] = 8'd2;
        collect(4'd14, 5'd4, 1'b0, 0, 0, 4);
        n_checks++; if (c_got !== 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", c_got); end
        for (int k = 0; k < 4 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== exp_w[k]) begin n_fail++; $display("FAIL wrap_word%0d: got %0d expected %0d", k, c_wd[k], exp_w[k]); end
            n_checks++; if (c_wl[k] !== (k == 3)) begin n_fail++; $display("FAIL wrap_last%0d: got %b expected %b", k, c_wl[k], k == 3); end
        end
        n_checks++; if (c_dones !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d expected 1", c_dones); end
    endtask

    task automatic test_stall();
        collect(4'd0, 5'd4, 1'b0, 1, 0, 4);
        n_checks++; if (c_got !== 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", c_got); end
        for (int k = 0; k < 4 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL stall_word%0d: got %0d expected %0d", k, c_wd[k], k + 1); end
            n_checks++; if (c_wl[k] !== (k == 3)) begin n_fail++; $display("FAIL stall_last%0d: got %b expected %b", k, c_wl[k], k == 3); end
        end
        n_checks++; if (c_held_ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b expected 1", c_held_ok); end
        n_checks++; if (c_dones !== 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", c_dones); end
    endtask

    task automatic test_loop_abort();
        collect(4'd2, 5'd2, 1'b1, 0, 5, 0);
        n_checks++; if (c_got !== 5) begin n_fail++; $display("FAIL loop_count: got %0d expected 5", c_got); end
        for (int k = 0; k < 5 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== ((k % 2 == 0) ? 8'd3 : 8'd4)) begin n_fail++; $display("FAIL loop_word%0d: got %0d expected %0d", k, c_wd[k], (k % 2 == 0) ? 3 : 4); end
            n_checks++; if (c_wl[k] !== (k % 2 == 1)) begin n_fail++; $display("FAIL loop_last%0d: got %b expected %b", k, c_wl[k], k % 2 == 1); end
            n_checks++; if (c_wc[k] !== c_wc[0] + k) begin n_fail++; $display("FAIL loop_gap%0d: got cycle %0d expected %0d", k, c_wc[k], c_wc[0] + k); end
        end
        n_checks++; if (c_post_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", c_post_valid); end
        n_checks++; if (c_post_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", c_post_busy); end
        n_checks++; if (c_dones !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", c_dones); end
    endtask

    task automatic test_len1_loop();
        collect(4'd7, 5'd1, 1'b1, 0, 3, 0);
        n_checks++; if (c_got !== 3) begin n_fail++; $display("FAIL len1_count: got %0d expected 3", c_got); end
        for (int k = 0; k < 3 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== 8'd8) begin n_fail++; $display("FAIL len1_word%0d: got %0d expected 8", k, c_wd[k]); end
            n_checks++; if (c_wl[k] !== 1'b1) begin n_fail++; $display("FAIL len1_last%0d: got %b expected 1", k, c_wl[k]); end
        end
        n_checks++; if (c_dones !== 0) begin n_fail++; $display("FAIL len1_done: got %0d expected 0", c_dones); end
    endtask

    task automatic test_full_depth();
        collect(4'd3, 5'd16, 1'b0, 0, 0, 16);
        n_checks++; if (c_got !== 16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", c_got); end
        for (int k = 0; k < 16 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== 8'(((3 + k) % 16) + 1)) begin n_fail++; $display("FAIL full_word%0d: got %0d expected %0d", k, c_wd[k], ((3 + k) % 16) + 1); end
            n_checks++; if (c_wl[k] !== (k == 15)) begin n_fail++; $display("FAIL full_last%0d: got %b expected %b", k, c_wl[k], k == 15); end
        end
        n_checks++; if (c_dones !== 1) begin n_fail++; $display("FAIL full_done: got %0d expected 1", c_dones); end
    endtask

    task automatic test_wr_err_len0();
        bit busy_seen, done_seen;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; len = 5'd4; loop_en = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrerr_busy: got %b expected 1", busy); end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL wrerr_pulse: got %b expected 1", wr_err); end
        @(negedge clk);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wrerr_width: got %b expected 0", wr_err); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrerr_abort_busy: got %b expected 0", busy); end
        collect(4'd5, 5'd1, 1'b0, 0, 0, 1);
        n_checks++; if (c_got !== 1) begin n_fail++; $display("FAIL reread_count: got %0d expected 1", c_got); end
        n_checks++; if (c_wd[0] !== 8'd6) begin n_fail++; $display("FAIL reread_word: got %0d expected 6", c_wd[0]); end
        n_checks++; if (c_wl[0] !== 1'b1) begin n_fail++; $display("FAIL reread_last: got %b expected 1", c_wl[0]); end
        busy_seen = 1'b0; done_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; len = 5'd0; loop_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (done || dout_valid) done_seen = 1'b1;
        end
        n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b expected 0", busy_seen); end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL len0_done: got %b expected 0", done_seen); end
    endtask

    task automatic test_back_to_back();
        bit got_done, got_valid;
        got_done = 1'b0; got_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 4'd9; len = 5'd1; loop_en = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got_done = 1'b1;
        end
        n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", got_done); end
        start = 1'b1; base_addr = 4'd10; len = 5'd1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
        for (int i = 0; i < 10 && !got_valid; i++) begin
            @(negedge clk);
            if (dout_valid) got_valid = 1'b1;
        end
        n_checks++; if (got_valid !== 1'b1 || dout !== 8'd11) begin n_fail++; $display("FAIL b2b_word: got valid %b data %0d expected valid 1 data 11", got_valid, dout); end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        start = 1'b1; base_addr = 4'd0; len = 5'd4; loop_en = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b expected 1", dout_valid); end
        rstN = 1'b0;
        @(negedge clk);
        n_checks++; if (dout !== 8'd0)       begin n_fail++; $display("FAIL mid_rst_dout: got %0d expected 0", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", dout_valid); end
        n_checks++; if (dout_last !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_last: got %b expected 0", dout_last); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", done); end
        n_checks++; if (wr_err !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_wr_err: got %b expected 0", wr_err); end
        rstN = 1'b1;
        @(negedge clk);
        collect(4'd0, 5'd4, 1'b0, 0, 0, 4);
        n_checks++; if (c_got !== 4) begin n_fail++; $display("FAIL retain_count: got %0d expected 4", c_got); end
        for (int k = 0; k < 4 && k < c_got; k++) begin
            n_checks++; if (c_wd[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL retain_word%0d: got %0d expected %0d", k, c_wd[k], k + 1); end
        end
        n_checks++; if (c_dones !== 1) begin n_fail++; $display("FAIL retain_done: got %0d expected 1", c_dones); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_oneshot();
        test_wrap();
        test_stall();
        test_loop_abort();
        test_len1_loop();
        test_full_depth();
        test_wr_err_len0();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
